adc_spi_reader: RTL and testbench
=================================

ADC_SPI_READER -- requirements
Module: adc_spi_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, ADC word length in bits (8..32).
REQ-002 SHALL have parameter SCK_HALF, default 2, adc_sck half-period in clk cycles (>=1).
REQ-003 SHALL have parameter CNV_CYCLES, default 3, adc_cnv high time in clk cycles (>=1).
REQ-004 SHALL have parameter BUSY_TIMEOUT, default 255, maximum clk cycles spent waiting for conversion end.
REQ-005 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1, one-cycle request for one conversion+readout from the acquisition FSM.
REQ-008 SHALL have port ready, output, 1, high when idle and able to accept start.
REQ-009 SHALL have port adc_cnv, output, 1, ADC conversion-start strobe.
REQ-010 SHALL have port adc_busy, input, 1, ADC busy flag, asynchronous to clk.
REQ-011 SHALL have port adc_sck, output, 1, SPI clock to ADC, idle low.
REQ-012 SHALL have port adc_miso, input, 1, SPI data from ADC, MSB first.
REQ-013 SHALL have port data, output, DATA_WIDTH, last completed ADC word.
REQ-014 SHALL have port data_valid, output, 1, one-cycle pulse when data updates.
REQ-015 SHALL have port timeout_err, output, 1, one-cycle pulse on busy timeout.

Function
REQ-016 SHALL implement states IDLE, CNV, WAIT_BUSY, SHIFT, DONE.
REQ-017 SHALL drive ready=1 exactly while in IDLE.
REQ-018 IDLE: start=1 SHALL move to CNV next cycle; start while not IDLE SHALL be ignored (not queued).
REQ-019 CNV: adc_cnv SHALL be high for exactly CNV_CYCLES cycles, beginning the cycle after start is sampled, then move to WAIT_BUSY.
REQ-020 adc_busy SHALL pass through a 2-flop synchronizer before use.
REQ-021 WAIT_BUSY: synchronized busy SHALL be ignored for the first 3 cycles (blanking); thereafter synchronized busy=0 SHALL move to SHIFT.
REQ-022 WAIT_BUSY: a cycle counter SHALL count from 0; on reaching BUSY_TIMEOUT without exit, timeout_err SHALL pulse one cycle, FSM SHALL return to IDLE, data unchanged, no data_valid.
REQ-023 SHIFT: DATA_WIDTH bit periods, each SCK_HALF cycles adc_sck low then SCK_HALF cycles high.
REQ-024 adc_miso SHALL be captured into a shift register on the clk edge where adc_sck goes 0->1; first captured bit = data MSB.
REQ-025 After the last high phase, adc_sck SHALL return low and FSM SHALL enter DONE.
REQ-026 DONE: data SHALL load the shift register and data_valid SHALL be high for exactly that cycle; next state IDLE.
REQ-027 SHIFT duration SHALL be exactly 2*SCK_HALF*DATA_WIDTH cycles; adc_sck SHALL be low in all states except SHIFT high phases.
REQ-028 data SHALL hold its value between data_valid pulses.
REQ-029 start asserted in the same cycle as data_valid SHALL be ignored (FSM not in IDLE).

Reset
REQ-030 rst low SHALL asynchronously force state IDLE, adc_cnv=0, adc_sck=0, data=0, data_valid=0, timeout_err=0, all counters and synchronizer flops 0.
REQ-031 rst low mid-conversion SHALL abort the transfer with no data_valid; after release ready=1 in the first clock cycle.
REQ-032 First start SHALL be accepted on the first rising clk edge after rst deasserts.

Verification
REQ-033 Defaults, start pulse, ADC model busy high 10 cycles after cnv, miso word 0xA5C3 -> adc_cnv high 3 cycles, 16 sck pulses of 4 clk period, data=0xA5C3 with one data_valid pulse, ready returns 1.
REQ-034 adc_busy held high forever -> timeout_err one pulse 255 cycles after entering WAIT_BUSY, no data_valid, data keeps previous value, ready=1 next cycle.
REQ-035 start re-pulsed during CNV, WAIT_BUSY and SHIFT -> ignored; exactly one data_valid per accepted start.
REQ-036 rst asserted during SHIFT bit 7 -> adc_sck=0, data=0 immediately, no data_valid; subsequent conversion of 0x0001 reads correctly.
REQ-037 DATA_WIDTH=12, SCK_HALF=1, word 0xFFF then 0x000 back-to-back -> 12 sck pulses at clk/2, data 0xFFF then 0x000, each with single data_valid.
REQ-038 adc_busy already low when CNV ends -> exit WAIT_BUSY after the 3-cycle blanking, SHIFT starts on 4th cycle.

Source files
------------

// File: rtl/adc_spi_reader.sv
// Single-shot ADC sequencer: strobes adc_cnv, waits for the ADC to drop busy,
// then clocks DATA_WIDTH bits MSB-first over SPI (mode 0) and presents the word.
module adc_spi_reader #(
    parameter int DATA_WIDTH   = 16,
    parameter int SCK_HALF     = 2,
    parameter int CNV_CYCLES   = 3,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ready,
    output logic                  adc_cnv,
    input  logic                  adc_busy,
    output logic                  adc_sck,
    input  logic                  adc_miso,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    output logic                  timeout_err
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int BLANK_CYCLES = 3;
    localparam int CNT_MAX      = max2(max2(BUSY_TIMEOUT, CNV_CYCLES), max2(SCK_HALF, BLANK_CYCLES));
    localparam int CNT_W        = $clog2(CNT_MAX + 1);
    localparam int BIT_W        = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] CNV_LAST     = CNT_W'(CNV_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END    = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_AT   = CNT_W'(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] HALF_LAST    = CNT_W'(SCK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CNV,
        WAIT_BUSY,
        SHIFT,
        DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [BIT_W-1:0]        bit_cnt, bit_cnt_nxt;
    logic                    sck_q, sck_nxt;
    logic [DATA_WIDTH-1:0]   shift_q, shift_nxt;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    cnv_q;
    logic                    busy_p0, busy_p1;
    logic                    busy_expired;

    // Registered state, SPI clock, conversion strobe and busy synchronizer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            sck_q   <= 1'b0;
            shift_q <= '0;
            data_q  <= '0;
            cnv_q   <= 1'b0;
            busy_p0 <= 1'b0;
            busy_p1 <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            sck_q   <= sck_nxt;
            shift_q <= shift_nxt;
            cnv_q   <= (state_nxt == CNV);
            busy_p0 <= adc_busy;
            busy_p1 <= busy_p0;
            // Load on entry to DONE so data and data_valid appear in the same cycle
            if (state_nxt == DONE) begin
                data_q <= shift_nxt;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        bit_cnt_nxt  = bit_cnt;
        sck_nxt      = 1'b0;
        shift_nxt    = shift_q;
        busy_expired = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt     = '0;
                bit_cnt_nxt = '0;
                if (start) begin
                    state_nxt = CNV;
                end
            end

            CNV: begin
                if (cnt == CNV_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT_BUSY;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            // Busy is only trusted from the fourth cycle on; the ADC may not
            // have raised it yet (plus synchronizer delay) right after cnv.
            WAIT_BUSY: begin
                if ((cnt >= BLANK_END) && !busy_p1) begin
                    cnt_nxt     = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                end else if (cnt == TIMEOUT_AT) begin
                    busy_expired = 1'b1;
                    cnt_nxt      = '0;
                    state_nxt    = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            SHIFT: begin
                sck_nxt = sck_q;
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    sck_nxt = ~sck_q;
                    if (!sck_q) begin
                        shift_nxt = {shift_q[DATA_WIDTH-2:0], adc_miso};
                    end else if (bit_cnt == BIT_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign ready       = (state == IDLE);
    assign adc_cnv     = cnv_q;
    assign adc_sck     = sck_q;
    assign data        = data_q;
    assign data_valid  = (state == DONE);
    assign timeout_err = busy_expired;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader: a 16-bit default instance and a 12-bit,
// SCK_HALF=1 instance, each driven by a small behavioural ADC.
module tb_adc_spi_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;

    // 16-bit instance
    logic        start = 1'b0;
    logic        ready, adc_cnv, adc_sck, data_valid, timeout_err;
    logic        adc_busy = 1'b0;
    logic        adc_miso;
    logic [15:0] data;

    // 12-bit instance
    logic        start_b = 1'b0;
    logic        ready_b, cnv_b, sck_b, dv_b, te_b;
    logic        busy_b = 1'b0;
    logic        miso_b;
    logic [11:0] data_b;

    adc_spi_reader dut_a (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .adc_cnv(adc_cnv),
        .adc_busy(adc_busy), .adc_sck(adc_sck), .adc_miso(adc_miso), .data(data),
        .data_valid(data_valid), .timeout_err(timeout_err)
    );

    adc_spi_reader #(.DATA_WIDTH(12), .SCK_HALF(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .ready(ready_b), .adc_cnv(cnv_b),
        .adc_busy(busy_b), .adc_sck(sck_b), .adc_miso(miso_b), .data(data_b),
        .data_valid(dv_b), .timeout_err(te_b)
    );

    // Behavioural ADCs: word latched at cnv rise, next bit driven on sck fall
    logic [15:0] word_a = 16'h0;
    logic [11:0] word_b = 12'h0;
    int          len_a = 0, len_b = 0;
    bit          busy_stuck = 1'b0;
    logic [15:0] tx_a;
    logic [11:0] tx_b;

    always @(posedge adc_cnv or negedge adc_sck)
        if (adc_cnv) tx_a <= word_a;
        else         tx_a <= {tx_a[14:0], 1'b0};
    assign adc_miso = tx_a[15];

    always @(posedge cnv_b or negedge sck_b)
        if (cnv_b) tx_b <= word_b;
        else       tx_b <= {tx_b[10:0], 1'b0};
    assign miso_b = tx_b[11];

    always @(posedge adc_cnv) begin
        if (busy_stuck) begin
            adc_busy <= 1'b1;
            wait (!busy_stuck);
            adc_busy <= 1'b0;
        end else if (len_a > 0) begin
            adc_busy <= 1'b1;
            repeat (len_a) @(posedge clk);
            #1 adc_busy <= 1'b0;
        end
    end

    always @(posedge cnv_b) begin
        if (len_b > 0) begin
            busy_b <= 1'b1;
            repeat (len_b) @(posedge clk);
            #1 busy_b <= 1'b0;
        end
    end

    // Event monitors
    int  cnv_cnt = 0, dv_cnt = 0, te_cnt = 0, dvb_cnt = 0;
    int  sck_cnt = 0, sckb_cnt = 0;
    time rise_t  [256];
    time rise_tb [256];

    always @(negedge clk) begin
        if (adc_cnv)     cnv_cnt <= cnv_cnt + 1;
        if (data_valid)  dv_cnt  <= dv_cnt + 1;
        if (timeout_err) te_cnt  <= te_cnt + 1;
        if (dv_b)        dvb_cnt <= dvb_cnt + 1;
    end

    always @(posedge adc_sck) begin
        rise_t[sck_cnt[7:0]] <= $time;
        sck_cnt <= sck_cnt + 1;
    end

    always @(posedge sck_b) begin
        rise_tb[sckb_cnt[7:0]] <= $time;
        sckb_cnt <= sckb_cnt + 1;
    end

    int  vectors = 0, miscompares = 0;
    time t_s;
    int  b_dv, b_cnv, b_te, b_sck;
    bit  ok;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_dv(input bit sel, input int max_cycles, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if ((sel ? dv_b : data_valid) === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic go_a();
        t_s   = $time;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready",   {31'd0, ready},       32'd1);
        check("rst_cnv",     {31'd0, adc_cnv},     32'd0);
        check("rst_sck",     {31'd0, adc_sck},     32'd0);
        check("rst_data",    {16'd0, data},        32'd0);
        check("rst_dv",      {31'd0, data_valid},  32'd0);
        check("rst_te",      {31'd0, timeout_err}, 32'd0);
        check("rst_ready_b", {31'd0, ready_b},     32'd1);

        // Nominal conversion, start accepted on first edge after reset release
        word_a = 16'hA5C3; len_a = 10;
        b_dv = dv_cnt; b_cnv = cnv_cnt; b_sck = sck_cnt;
        rst = 1'b1;
        go_a();
        check("first_start_cnv",   {31'd0, adc_cnv}, 32'd1);
        check("first_start_ready", {31'd0, ready},   32'd0);
        wait_dv(1'b0, 200, ok);
        check("nom_dv_seen", {31'd0, ok}, 32'd1);
        check("nom_data", {16'd0, data}, 32'h0000A5C3);
        check("nom_dv_time", 32'($time - t_s), 32'd780);
        check("nom_first_rise", 32'(rise_t[b_sck[7:0]] - t_s), 32'd155);
        check("nom_sck_span", 32'(rise_t[8'(b_sck + 15)] - rise_t[b_sck[7:0]]), 32'd600);
        check("nom_sck_count", 32'(sck_cnt - b_sck), 32'd16);
        @(negedge clk);
        check("nom_ready_after", {31'd0, ready},      32'd1);
        check("nom_dv_one_cycle", {31'd0, data_valid}, 32'd0);
        repeat (5) @(negedge clk);
        check("nom_dv_count",  32'(dv_cnt - b_dv),   32'd1);
        check("nom_cnv_width", 32'(cnv_cnt - b_cnv), 32'd3);
        check("nom_data_hold", {16'd0, data}, 32'h0000A5C3);
        check("nom_sck_idle",  {31'd0, adc_sck}, 32'd0);

        // Busy never asserted: leave WAIT_BUSY right after blanking
        word_a = 16'h5A0F; len_a = 0;
        b_sck = sck_cnt;
        go_a();
        wait_dv(1'b0, 200, ok);
        check("nobusy_dv_seen", {31'd0, ok}, 32'd1);
        check("nobusy_data", {16'd0, data}, 32'h00005A0F);
        check("nobusy_first_rise", 32'(rise_t[b_sck[7:0]] - t_s), 32'd95);
        check("nobusy_dv_time", 32'($time - t_s), 32'd720);
        repeat (3) @(negedge clk);

        // Busy stuck high: timeout
        busy_stuck = 1'b1;
        b_dv = dv_cnt; b_te = te_cnt;
        go_a();
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (timeout_err === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("to_seen", {31'd0, ok}, 32'd1);
        check("to_time", 32'($time - t_s), 32'd2590);
        @(negedge clk);
        check("to_ready_next", {31'd0, ready},       32'd1);
        check("to_one_pulse",  {31'd0, timeout_err}, 32'd0);
        busy_stuck = 1'b0;
        repeat (3) @(negedge clk);
        check("to_te_count", 32'(te_cnt - b_te), 32'd1);
        check("to_no_dv",    32'(dv_cnt - b_dv), 32'd0);
        check("to_data_kept", {16'd0, data}, 32'h00005A0F);

        // Start re-pulsed in CNV, WAIT_BUSY, SHIFT and DONE: all ignored
        word_a = 16'h3C96; len_a = 10;
        b_dv = dv_cnt; b_cnv = cnv_cnt;
        go_a();
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        check("ign_in_shift", {31'd0, ready}, 32'd0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_dv(1'b0, 200, ok);
        check("ign_dv_seen", {31'd0, ok}, 32'd1);
        check("ign_data", {16'd0, data}, 32'h00003C96);
        start = 1'b1; @(negedge clk); start = 1'b0;
        check("ign_done_ready", {31'd0, ready}, 32'd1);
        repeat (5) @(negedge clk);
        check("ign_done_no_cnv", {31'd0, adc_cnv}, 32'd0);
        check("ign_dv_count",  32'(dv_cnt - b_dv),   32'd1);
        check("ign_cnv_count", 32'(cnv_cnt - b_cnv), 32'd3);

        // Reset during bit 7 of SHIFT
        word_a = 16'hFFFF; len_a = 0;
        b_dv = dv_cnt; b_sck = sck_cnt;
        go_a();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sck_cnt - b_sck >= 8) begin
                ok = 1'b1;
                break;
            end
        end
        check("rstmid_reached_bit7", {31'd0, ok}, 32'd1);
        check("rstmid_sck_high", {31'd0, adc_sck}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rstmid_sck",   {31'd0, adc_sck},    32'd0);
        check("rstmid_data",  {16'd0, data},       32'd0);
        check("rstmid_ready", {31'd0, ready},      32'd1);
        check("rstmid_dv",    {31'd0, data_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_no_dv", 32'(dv_cnt - b_dv), 32'd0);
        check("rstmid_data_held", {16'd0, data}, 32'd0);
        word_a = 16'h0001;
        go_a();
        wait_dv(1'b0, 200, ok);
        check("post_rst_dv_seen", {31'd0, ok}, 32'd1);
        check("post_rst_data", {16'd0, data}, 32'h00000001);

        // 12-bit instance, SCK_HALF=1, back-to-back words
        word_b = 12'hFFF; len_b = 2;
        b_dv = dvb_cnt; b_sck = sckb_cnt;
        start_b = 1'b1; @(negedge clk); start_b = 1'b0;
        wait_dv(1'b1, 200, ok);
        check("b1_dv_seen", {31'd0, ok}, 32'd1);
        check("b1_data", {20'd0, data_b}, 32'h00000FFF);
        check("b1_sck_count", 32'(sckb_cnt - b_sck), 32'd12);
        check("b1_sck_span", 32'(rise_tb[8'(b_sck + 11)] - rise_tb[b_sck[7:0]]), 32'd220);
        word_b = 12'h000;
        @(negedge clk);
        check("b_ready_between", {31'd0, ready_b}, 32'd1);
        start_b = 1'b1; @(negedge clk); start_b = 1'b0;
        wait_dv(1'b1, 200, ok);
        check("b2_dv_seen", {31'd0, ok}, 32'd1);
        check("b2_data", {20'd0, data_b}, 32'h00000000);
        repeat (3) @(negedge clk);
        check("b_dv_count",  32'(dvb_cnt - b_dv),   32'd2);
        check("b_sck_total", 32'(sckb_cnt - b_sck), 32'd24);
        check("b_no_timeout", {31'd0, te_b}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
